// File: rtl/key_debounce_evt_pkg.sv
// Shared definitions for the key debouncer / event queue.
//   key_fsm_e   : per-key debounce state
//   evt_rel_bit : bit position of the release flag inside evt_code
package key_debounce_evt_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED    = 2'd0,
    KEY_PRESS_CHK   = 2'd1,
    KEY_PRESSED     = 2'd2,
    KEY_RELEASE_CHK = 2'd3
  } key_fsm_e;

  // evt_code = {release_flag, key_index}; the flag sits just above the index.
  function automatic int unsigned evt_rel_bit(input int unsigned nkeys);
    return $clog2(nkeys);
  endfunction

endpackage

// File: rtl/key_db_cell.sv
// One button: 2-flop synchronizer, debounce FSM with agreement counter,
// and registered one-cycle press/release pulses.
//   clk_i, rst_ni   : clock, async active-low reset
//   sample_en_i     : one-cycle sample strobe; the FSM only moves on it
//   key_raw_i       : asynchronous raw pin
//   key_state_o     : debounced level (1 = pressed)
//   key_press_o     : one-cycle pulse per debounced press
//   key_release_o   : one-cycle pulse per debounced release
module key_db_cell
  import key_debounce_evt_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_en_i,
  input  logic key_raw_i,
  output logic key_state_o,
  output logic key_press_o,
  output logic key_release_o
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT);
  // Pin level of a released key; synchronizer resets here so no phantom press.
  localparam logic             REL_LVL  = (ACTIVE_LOW != 0);

  logic             sync1_q, sync2_q;
  logic             sync_p;
  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_p = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= KEY_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt_q + 1'b1;
    if (sample_en_i) begin
      unique case (state_q)
        KEY_RELEASED: begin
          if (sync_p) begin
            if (STABLE_CNT == 1) begin
              state_d = KEY_PRESSED;
              press_d = 1'b1;
            end else begin
              state_d = KEY_PRESS_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        KEY_PRESS_CHK: begin
          if (sync_p) begin
            if (cnt_inc == CNT_LAST) begin
              state_d = KEY_PRESSED;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = KEY_RELEASED;
            cnt_d   = '0;
          end
        end
        KEY_PRESSED: begin
          if (!sync_p) begin
            if (STABLE_CNT == 1) begin
              state_d   = KEY_RELEASED;
              release_d = 1'b1;
            end else begin
              state_d = KEY_RELEASE_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        KEY_RELEASE_CHK: begin
          if (!sync_p) begin
            if (cnt_inc == CNT_LAST) begin
              state_d   = KEY_RELEASED;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = KEY_PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = KEY_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign key_state_o   = (state_q == KEY_PRESSED) || (state_q == KEY_RELEASE_CHK);
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: rtl/key_debounce_evt.sv
// Console button debouncer with a single-entry key-event output.
// The divided clock is used only as a sample strobe (rising edge detect)
// in the clk_in domain.
//   clk_in, resetn : system clock, async active-low reset
//   tick_clk       : divided clock, synchronous to clk_in
//   key_raw        : raw button pins (asynchronous)
//   key_state      : debounced levels (1 = pressed)
//   key_press      : one-cycle pulse per debounced press
//   key_release    : one-cycle pulse per debounced release
//   evt_valid      : an event is presented on evt_code
//   evt_code       : {release_flag, key_index}
//   evt_ack        : consume the presented event
//   evt_ovf        : sticky, an event was lost
//   ovf_clr        : clears evt_ovf
module key_debounce_evt
  import key_debounce_evt_pkg::*;
#(
  parameter int unsigned NKEYS      = 8,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                   clk_in,
  input  logic                   resetn,
  input  logic                   tick_clk,
  input  logic [NKEYS-1:0]       key_raw,
  output logic [NKEYS-1:0]       key_state,
  output logic [NKEYS-1:0]       key_press,
  output logic [NKEYS-1:0]       key_release,
  output logic                   evt_valid,
  output logic [$clog2(NKEYS):0] evt_code,
  input  logic                   evt_ack,
  output logic                   evt_ovf,
  input  logic                   ovf_clr
);

  localparam int unsigned IDX_W   = $clog2(NKEYS);
  localparam int unsigned CODE_W  = IDX_W + 1;
  localparam int unsigned REL_BIT = evt_rel_bit(NKEYS);

  // Resets high to match the divider's reset-high output: no false edge.
  logic tick_prev_q;
  logic sample_en;

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) tick_prev_q <= 1'b1;
    else         tick_prev_q <= tick_clk;
  end

  assign sample_en = tick_clk & ~tick_prev_q;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_db_cell #(
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_cell (
      .clk_i         (clk_in),
      .rst_ni        (resetn),
      .sample_en_i   (sample_en),
      .key_raw_i     (key_raw[g]),
      .key_state_o   (key_state[g]),
      .key_press_o   (key_press[g]),
      .key_release_o (key_release[g])
    );
  end

  logic [NKEYS-1:0]  pend_p_q, pend_p_d, pend_r_q, pend_r_d;
  logic [NKEYS-1:0]  clr_p, clr_r;
  logic              evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0] evt_code_q, evt_code_d;
  logic              evt_ovf_q, evt_ovf_d;
  logic              load, hit, sel_rel, ovf_set;
  logic [IDX_W-1:0]  sel_idx;

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      pend_p_q    <= '0;
      pend_r_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      pend_p_q    <= pend_p_d;
      pend_r_q    <= pend_r_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  always_comb begin
    load        = ~evt_valid_q | evt_ack;
    hit         = 1'b0;
    sel_rel     = 1'b0;
    sel_idx     = '0;
    clr_p       = '0;
    clr_r       = '0;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;

    // Lowest index wins; a pending press is served before its release.
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (!hit && (pend_p_q[i] || pend_r_q[i])) begin
        hit      = 1'b1;
        sel_idx  = IDX_W'(i);
        sel_rel  = ~pend_p_q[i];
        clr_p[i] = load & pend_p_q[i];
        clr_r[i] = load & ~pend_p_q[i];
      end
    end

    if (load) begin
      evt_valid_d = hit;
      evt_code_d  = '0;
      if (hit) begin
        evt_code_d[IDX_W-1:0] = sel_idx;
        evt_code_d[REL_BIT]   = sel_rel;
      end
    end

    // A bit being cleared by the load this cycle is free to take a new set.
    ovf_set   = |((key_press & pend_p_q & ~clr_p) | (key_release & pend_r_q & ~clr_r));
    pend_p_d  = (pend_p_q & ~clr_p) | key_press;
    pend_r_d  = (pend_r_q & ~clr_r) | key_release;
    evt_ovf_d = ovf_set | (evt_ovf_q & ~ovf_clr);
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_key_debounce_evt.sv
module tb_key_debounce_evt;

  localparam int NKEYS      = 8;
  localparam int STABLE_CNT = 4;
  localparam int ACTIVE_LOW = 1;
  localparam int CW         = $clog2(NKEYS) + 1;

  logic             clk_in = 1'b0;
  logic             resetn = 1'b0;
  logic             tick_clk = 1'b1;
  logic [NKEYS-1:0] key_raw = '1;
  logic [NKEYS-1:0] key_state, key_press, key_release;
  logic             evt_valid;
  logic [CW-1:0]    evt_code;
  logic             evt_ack = 1'b0;
  logic             evt_ovf;
  logic             ovf_clr = 1'b0;

  always #5 clk_in = ~clk_in;

  key_debounce_evt #(
    .NKEYS      (NKEYS),
    .STABLE_CNT (STABLE_CNT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk_in      (clk_in),
    .resetn      (resetn),
    .tick_clk    (tick_clk),
    .key_raw     (key_raw),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ack     (evt_ack),
    .evt_ovf     (evt_ovf),
    .ovf_clr     (ovf_clr)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural reference model ----------------
  bit             m_tick_prev;
  bit [NKEYS-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_pp, m_pr;
  int             m_run [NKEYS];
  bit             m_valid;
  bit [CW-1:0]    m_code;
  bit             m_ovf;

  int tc = 0;
  bit rand_tick = 1'b0;

  task automatic model_reset();
    m_tick_prev = 1'b1;
    m_s1 = (ACTIVE_LOW != 0) ? '1 : '0;
    m_s2 = m_s1;
    m_level = '0; m_press = '0; m_rel = '0; m_pp = '0; m_pr = '0;
    for (int i = 0; i < NKEYS; i++) m_run[i] = 0;
    m_valid = 1'b0; m_code = '0; m_ovf = 1'b0;
  endtask

  // Debounced level flips once STABLE_CNT consecutive samples disagree with it.
  task automatic model_step(input logic [NKEYS-1:0] raw, input bit tick,
                            input bit ack, input bit clr);
    bit se, found, load, ovfset;
    bit [NKEYS-1:0] now_p, np, nr, cp, cr;
    se = tick && !m_tick_prev;
    now_p = (ACTIVE_LOW != 0) ? ~m_s2 : m_s2;
    np = '0; nr = '0; cp = '0; cr = '0;
    if (se) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (now_p[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == STABLE_CNT) begin
            m_run[i] = 0;
            m_level[i] = ~m_level[i];
            if (m_level[i]) np[i] = 1'b1; else nr[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    load = !m_valid || ack;
    if (load) begin
      found = 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
        if (!found && (m_pp[i] || m_pr[i])) begin
          found = 1'b1;
          m_code = CW'(i);
          if (m_pp[i]) cp[i] = 1'b1;
          else begin cr[i] = 1'b1; m_code[CW-1] = 1'b1; end
        end
      end
      m_valid = found;
      if (!found) m_code = '0;
    end
    ovfset = |((m_press & m_pp & ~cp) | (m_rel & m_pr & ~cr));
    m_ovf = ovfset || (m_ovf && !clr);
    m_pp = (m_pp & ~cp) | m_press;
    m_pr = (m_pr & ~cr) | m_rel;
    m_press = np; m_rel = nr;
    m_s2 = m_s1; m_s1 = raw;
    m_tick_prev = tick;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    checks++;
    if (key_state !== m_level || key_press !== m_press || key_release !== m_rel ||
        evt_valid !== m_valid || (m_valid && evt_code !== m_code) || evt_ovf !== m_ovf) begin
      errors++;
      $display("FAIL model t=%0t: state %h/%h press %h/%h rel %h/%h valid %b/%b code %h/%h ovf %b/%b (got/expected)",
               $time, key_state, m_level, key_press, m_press, key_release, m_rel,
               evt_valid, m_valid, evt_code, m_code, evt_ovf, m_ovf);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, 32'({key_state, key_press, key_release, evt_valid, evt_code, evt_ovf}), 32'd0);
  endtask

  // Called at a negedge: drive inputs, advance one clock, check against model.
  task automatic step(input logic [NKEYS-1:0] raw, input bit ack, input bit clr);
    bit t;
    t = rand_tick ? 1'($urandom_range(0, 1)) : (tc < 2);
    tc = (tc + 1) % 4;
    key_raw = raw; evt_ack = ack; ovf_clr = clr; tick_clk = t;
    @(posedge clk_in);
    model_step(raw, t, ack, clr);
    @(negedge clk_in);
    check_model();
  endtask

  task automatic hold(input logic [NKEYS-1:0] raw, input bit ack, input int n);
    repeat (n) step(raw, ack, 1'b0);
  endtask

  task automatic wait_valid(input logic [NKEYS-1:0] raw, input string name);
    int k = 0;
    while (evt_valid !== 1'b1 && k < 64) begin
      step(raw, 1'b0, 1'b0);
      k++;
    end
    check({name, "_valid"}, 32'(evt_valid), 32'd1);
  endtask

  typedef struct {
    logic [NKEYS-1:0] raw;
    bit               ack;
    int               n;
    logic [NKEYS-1:0] e_state, e_press, e_rel;
    bit               e_valid;
    logic [CW-1:0]    e_code;
    int               e_npress;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npress;
    logic [NKEYS-1:0] intent, glitch;

    // Step n = n-th clk_in edge after reset release; strobes fall on n = 5, 9, 13, ...
    vecs[0]  = '{8'hFB, 0, 16, 8'h00, 8'h00, 8'h00, 0, 4'h0, 0};
    vecs[1]  = '{8'hFB, 0, 1,  8'h04, 8'h04, 8'h00, 0, 4'h0, 1};
    vecs[2]  = '{8'hFB, 0, 1,  8'h04, 8'h00, 8'h00, 0, 4'h0, 0};
    vecs[3]  = '{8'hFB, 0, 1,  8'h04, 8'h00, 8'h00, 1, 4'b0010, 0};
    vecs[4]  = '{8'hFB, 0, 5,  8'h04, 8'h00, 8'h00, 1, 4'b0010, 0};
    vecs[5]  = '{8'hFB, 1, 1,  8'h04, 8'h00, 8'h00, 0, 4'h0, 0};
    vecs[6]  = '{8'hFB, 0, 1,  8'h04, 8'h00, 8'h00, 0, 4'h0, 0};
    vecs[7]  = '{8'hFF, 0, 14, 8'h04, 8'h00, 8'h00, 0, 4'h0, 0};
    vecs[8]  = '{8'hFF, 0, 1,  8'h00, 8'h00, 8'h04, 0, 4'h0, 0};
    vecs[9]  = '{8'hFF, 0, 2,  8'h00, 8'h00, 8'h00, 1, 4'b1010, 0};
    vecs[10] = '{8'hFF, 1, 1,  8'h00, 8'h00, 8'h00, 0, 4'h0, 0};

    model_reset();
    repeat (3) @(negedge clk_in);
    check_zero("reset_outputs");
    resetn = 1'b1;
    tc = 0;

    // Clean press/release of key 2 with hand-derived timing.
    for (int v = 0; v < 11; v++) begin
      npress = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        step(vecs[v].raw, vecs[v].ack, 1'b0);
        npress += $countones(key_press);
      end
      check($sformatf("vec%0d_state", v), 32'(key_state), 32'(vecs[v].e_state));
      check($sformatf("vec%0d_press", v), 32'(key_press), 32'(vecs[v].e_press));
      check($sformatf("vec%0d_release", v), 32'(key_release), 32'(vecs[v].e_rel));
      check($sformatf("vec%0d_valid", v), 32'(evt_valid), 32'(vecs[v].e_valid));
      if (vecs[v].e_valid)
        check($sformatf("vec%0d_code", v), 32'(evt_code), 32'(vecs[v].e_code));
      check($sformatf("vec%0d_npress", v), 32'(npress), 32'(vecs[v].e_npress));
    end

    // Key 0 bouncing on alternate strobes never qualifies.
    npress = 0;
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 4; k++) begin
        step((s % 2 == 0) ? 8'hFE : 8'hFF, 1'b0, 1'b0);
        npress += $countones(key_press);
      end
    end
    hold(8'hFF, 1'b0, 8);
    check("bounce_npress", 32'(npress), 32'd0);
    check("bounce_state", 32'(key_state[0]), 32'd0);
    check("bounce_valid", 32'(evt_valid), 32'd0);

    // Keys 5 and 1 together: lower index first, code held without ack.
    wait_valid(8'hDD, "dual");
    check("dual_first", 32'(evt_code), 32'b0001);
    hold(8'hDD, 1'b0, 3);
    check("dual_hold", 32'({evt_valid, evt_code}), 32'b1_0001);
    step(8'hDD, 1'b1, 1'b0);
    check("dual_second", 32'({evt_valid, evt_code}), 32'b1_0101);
    step(8'hDD, 1'b1, 1'b0);
    check("dual_empty", 32'(evt_valid), 32'd0);
    hold(8'hFF, 1'b1, 32);
    check("dual_drained", 32'(evt_valid), 32'd0);

    // Key 3 press then release, no ack: ordered codes, no overflow.
    hold(8'hF7, 1'b0, 24);
    hold(8'hFF, 1'b0, 24);
    check("k3_press", 32'({evt_valid, evt_code}), 32'b1_0011);
    step(8'hFF, 1'b1, 1'b0);
    check("k3_release", 32'({evt_valid, evt_code}), 32'b1_1011);
    check("k3_ovf", 32'(evt_ovf), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    check("k3_empty", 32'(evt_valid), 32'd0);

    // Key 7 press/release/press/release, no ack: second release overflows.
    hold(8'h7F, 1'b0, 24);
    hold(8'hFF, 1'b0, 24);
    check("k7_no_ovf_yet", 32'(evt_ovf), 32'd0);
    hold(8'h7F, 1'b0, 24);
    hold(8'hFF, 1'b0, 24);
    check("k7_ovf", 32'(evt_ovf), 32'd1);
    check("k7_head", 32'({evt_valid, evt_code}), 32'b1_0111);
    step(8'hFF, 1'b0, 1'b1);
    check("k7_ovf_clr", 32'(evt_ovf), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    check("k7_pend_press", 32'({evt_valid, evt_code}), 32'b1_0111);
    step(8'hFF, 1'b1, 1'b0);
    check("k7_pend_release", 32'({evt_valid, evt_code}), 32'b1_1111);
    step(8'hFF, 1'b1, 1'b0);
    check("k7_empty", 32'(evt_valid), 32'd0);

    // Reset in the middle of an event and of key 6's debounce.
    wait_valid(8'hEF, "k4");
    hold(8'hAF, 1'b0, 8);
    check("pre_reset_valid", 32'(evt_valid), 32'd1);
    #2 resetn = 1'b0;
    tick_clk = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    tc = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    resetn = 1'b1;
    npress = 0;
    for (int k = 0; k < 16; k++) begin
      step(8'hBF, 1'b0, 1'b0);
      npress += $countones(key_press);
    end
    check("post_reset_no_press", 32'(npress), 32'd0);
    step(8'hBF, 1'b0, 1'b0);
    check("post_reset_press", 32'(key_press), 32'h40);
    hold(8'hFF, 1'b1, 32);

    // Randomized traffic against the reference model.
    rand_tick = 1'b1;
    intent = '1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NKEYS; i++) begin
        if ($urandom_range(0, 39) == 0) intent[i] = ~intent[i];
        glitch[i] = ($urandom_range(0, 19) == 0);
      end
      step(intent ^ glitch, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
